// File: rtl/array_stream_to_3d.sv
// Assembles a row-major element stream into a ROWS x COLS array and hands the
// completed frame downstream with a valid/ready handshake.
module array_stream_to_3d #(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [BIT_WIDTH-1:0] out [ROWS][COLS],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_error
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state, state_nxt;
  logic [ROW_W-1:0] row, row_nxt;
  logic [COL_W-1:0] col, col_nxt;
  logic             accept;
  logic             at_final;
  logic             err_nxt;

  assign in_ready = (state == FILL) && !rst;
  assign accept   = in_valid && in_ready;
  assign at_final = (row == ROW_LAST) && (col == COL_LAST);

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    err_nxt   = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          if (at_final) begin
            // A full frame is delivered even when in_last is missing.
            state_nxt = HOLD;
            row_nxt   = '0;
            col_nxt   = '0;
            err_nxt   = !in_last;
          end else if (in_last) begin
            // Early last: drop the partial frame and restart at [0][0].
            row_nxt = '0;
            col_nxt = '0;
            err_nxt = 1'b1;
          end else if (col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = row + 1'b1;
          end else begin
            col_nxt = col + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      row         <= '0;
      col         <= '0;
      out_valid   <= 1'b0;
      frame_error <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          out[r][c] <= '0;
    end else begin
      state       <= state_nxt;
      row         <= row_nxt;
      col         <= col_nxt;
      out_valid   <= (state_nxt == HOLD);
      frame_error <= err_nxt;
      if (accept) out[row][col] <= in_data;
    end
  end

endmodule

// File: tb/tb_array_stream_to_3d.sv
// Scoreboard bench for array_stream_to_3d: an 8x8 instance for the long frame
// and a 2x3 instance for handshake, framing-error and reset scenarios.
module tb_array_stream_to_3d;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] s_in_data, b_in_data;
  logic       s_in_valid, s_in_last, s_in_ready, b_in_valid, b_in_last, b_in_ready;
  logic [3:0] s_out [2][3];
  logic [3:0] b_out [8][8];
  logic       s_out_valid, s_out_ready, s_frame_error;
  logic       b_out_valid, b_out_ready, b_frame_error;

  array_stream_to_3d #(.BIT_WIDTH(4), .ROWS(2), .COLS(3)) u_small (
    .clk(clk), .rst(rst), .in_data(s_in_data), .in_valid(s_in_valid),
    .in_last(s_in_last), .in_ready(s_in_ready), .out(s_out),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .frame_error(s_frame_error)
  );

  array_stream_to_3d #(.BIT_WIDTH(4), .ROWS(8), .COLS(8)) u_big (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_last(b_in_last), .in_ready(b_in_ready), .out(b_out),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .frame_error(b_frame_error)
  );

  int passed = 0;
  int total  = 0;
  int s_fe_cnt = 0;
  int b_fe_cnt = 0;
  logic [23:0]  s_exp_q [$];
  logic [255:0] b_exp_q [$];
  logic [23:0]  s_flat, s_pop;
  logic [255:0] b_flat, b_pop;
  bit done;

  always_comb begin
    s_flat = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        s_flat[4*(r*3+c) +: 4] = s_out[r][c];
  end

  always_comb begin
    b_flat = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b_flat[4*(r*8+c) +: 4] = b_out[r][c];
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Monitors: a frame is consumed on the edge following a valid&&ready sample.
  always @(negedge clk) begin
    if (s_frame_error) s_fe_cnt++;
    if (b_frame_error) b_fe_cnt++;
    if (!rst && s_out_valid && s_out_ready) begin
      check("s_frame_expected", 256'(s_exp_q.size() != 0), 256'(1));
      if (s_exp_q.size() != 0) begin
        s_pop = s_exp_q.pop_front();
        check("s_frame", s_flat, s_pop);
      end
    end
    if (!rst && b_out_valid && b_out_ready) begin
      check("b_frame_expected", 256'(b_exp_q.size() != 0), 256'(1));
      if (b_exp_q.size() != 0) begin
        b_pop = b_exp_q.pop_front();
        check("b_frame", b_flat, b_pop);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic s_send(input logic [3:0] d, input logic l);
    int t = 0;
    s_in_data  = d;
    s_in_valid = 1'b1;
    s_in_last  = l;
    do begin
      @(negedge clk);
      t++;
    end while (!s_in_ready && t < 300);
    if (!s_in_ready) check("s_accept_timeout", 256'(s_in_ready), 256'(1));
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    s_in_last  = 1'b0;
  endtask

  task automatic b_send(input logic [3:0] d, input logic l);
    int t = 0;
    b_in_data  = d;
    b_in_valid = 1'b1;
    b_in_last  = l;
    do begin
      @(negedge clk);
      t++;
    end while (!b_in_ready && t < 300);
    if (!b_in_ready) check("b_accept_timeout", 256'(b_in_ready), 256'(1));
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
  endtask

  // Sends the first n elements of f; in_last on element last_at (-1: never).
  task automatic s_frame(input logic [23:0] f, input int n, input int last_at, input bit bubbles);
    for (int i = 0; i < n; i++) begin
      if (bubbles && $urandom_range(1) == 1) idle(1);
      s_send(f[4*i +: 4], i == last_at);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [23:0]  f;
    logic [255:0] bf;
    int t;
    rst = 1'b1;
    s_in_data = '0; s_in_valid = 1'b0; s_in_last = 1'b0; s_out_ready = 1'b0;
    b_in_data = '0; b_in_valid = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b0;
    done = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_in_ready", 256'(s_in_ready), 256'(0));
    check("rst_b_in_ready", 256'(b_in_ready), 256'(0));
    check("rst_s_out_valid", 256'(s_out_valid), 256'(0));
    check("rst_b_out_valid", 256'(b_out_valid), 256'(0));
    check("rst_s_frame_error", 256'(s_frame_error), 256'(0));
    check("rst_s_out", s_flat, 256'(0));
    check("rst_b_out", b_flat, 256'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("post_rst_s_in_ready", 256'(s_in_ready), 256'(1));
    check("post_rst_b_in_ready", 256'(b_in_ready), 256'(1));

    // 8x8 back-to-back frame, values (8r+c)%16
    b_out_ready = 1'b1;
    for (int i = 0; i < 64; i++) bf[4*i +: 4] = 4'(i % 16);
    b_exp_q.push_back(bf);
    for (int i = 0; i < 64; i++) begin
      b_send(4'(i), i == 63);
      if (i == 62) check("b_valid_before_last", 256'(b_out_valid), 256'(0));
    end
    check("b_valid_after_last", 256'(b_out_valid), 256'(1));
    check("b_out_63", 256'(b_out[7][7]), 256'(4'hF));
    check("b_no_frame_error", 256'(b_frame_error), 256'(0));
    idle(1);
    check("b_valid_falls", 256'(b_out_valid), 256'(0));
    check("b_in_ready_back", 256'(b_in_ready), 256'(1));

    // 2x3 backpressure
    s_out_ready = 1'b0;
    f = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    s_exp_q.push_back(f);
    s_frame(f, 6, 5, 1'b0);
    check("s_bp_valid", 256'(s_out_valid), 256'(1));
    s_in_valid = 1'b1;
    s_in_data  = 4'd6;
    repeat (10) begin
      @(negedge clk);
      check("s_bp_in_ready", 256'(s_in_ready), 256'(0));
      check("s_bp_stable", s_flat, f);
    end
    @(posedge clk);
    #1 s_out_ready = 1'b1;
    idle(1);
    check("s_bp_release_ready", 256'(s_in_ready), 256'(1));
    check("s_bp_release_valid", 256'(s_out_valid), 256'(0));
    f = {4'd11, 4'd10, 4'd9, 4'd8, 4'd7, 4'd6};
    s_exp_q.push_back(f);
    s_frame(f, 6, 5, 1'b0);
    idle(1);

    // Early last on the 4th element
    s_frame({4'd0, 4'd0, 4'd4, 4'd3, 4'd2, 4'd1}, 4, 3, 1'b0);
    check("early_err_pulse", 256'(s_frame_error), 256'(1));
    check("early_no_valid", 256'(s_out_valid), 256'(0));
    idle(1);
    check("early_err_clear", 256'(s_frame_error), 256'(0));
    check("early_still_no_valid", 256'(s_out_valid), 256'(0));
    f = {4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA};
    s_exp_q.push_back(f);
    s_frame(f, 6, 5, 1'b0);
    check("early_next_valid", 256'(s_out_valid), 256'(1));
    check("early_next_out12", 256'(s_out[1][2]), 256'(4'hF));
    check("early_next_no_err", 256'(s_frame_error), 256'(0));
    idle(1);

    // Missing last
    f = {4'd9, 4'd5, 4'd1, 4'd4, 4'd1, 4'd3};
    s_exp_q.push_back(f);
    s_frame(f, 6, -1, 1'b0);
    check("miss_valid", 256'(s_out_valid), 256'(1));
    check("miss_err_pulse", 256'(s_frame_error), 256'(1));
    idle(1);
    check("miss_err_clear", 256'(s_frame_error), 256'(0));

    // 20 frames with random bubbles and random out_ready
    fork
      begin
        for (int fr = 0; fr < 20; fr++) begin
          for (int i = 0; i < 6; i++) f[4*i +: 4] = 4'((fr * 5 + i * 3 + 1) % 16);
          s_exp_q.push_back(f);
          s_frame(f, 6, 5, 1'b1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 s_out_ready = 1'($urandom_range(1));
        end
      end
    join
    s_out_ready = 1'b1;
    t = 0;
    while (s_exp_q.size() != 0 && t < 50) begin
      idle(1);
      t++;
    end
    check("rand_queue_drained", 256'(s_exp_q.size()), 256'(0));
    check("rand_err_count", 256'(s_fe_cnt), 256'(2));

    // Reset mid-fill, then during HOLD
    s_out_ready = 1'b0;
    s_frame({4'd0, 4'd0, 4'd0, 4'd7, 4'd7, 4'd7}, 3, -1, 1'b0);
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    check("midfill_rst_valid", 256'(s_out_valid), 256'(0));
    check("midfill_rst_out", s_flat, 256'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    f = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    s_exp_q.push_back(f);
    s_frame(f, 6, 5, 1'b0);
    check("hold_valid", 256'(s_out_valid), 256'(1));
    check("hold_out", s_flat, f);
    rst = 1'b1;
    void'(s_exp_q.pop_back());
    idle(2);
    @(negedge clk);
    check("hold_rst_valid", 256'(s_out_valid), 256'(0));
    check("hold_rst_out", s_flat, 256'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    s_out_ready = 1'b1;
    f = {4'hC, 4'h2, 4'h8, 4'h4, 4'h6, 4'h9};
    s_exp_q.push_back(f);
    s_frame(f, 6, 5, 1'b0);
    check("post_rst_out00", 256'(s_out[0][0]), 256'(4'h9));
    idle(3);

    check("s_queue_empty", 256'(s_exp_q.size()), 256'(0));
    check("b_queue_empty", 256'(b_exp_q.size()), 256'(0));
    check("b_err_count", 256'(b_fe_cnt), 256'(0));
    check("s_err_count_final", 256'(s_fe_cnt), 256'(2));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
